// File: rtl/dom_indep_mul_ft.sv
`default_nettype none
// ============================================================================
// Module   : dom_indep_mul_ft
// Purpose  : Order-D DOM-indep masked AND gadget with a single register stage.
//            Define DOM_FAULT_CHECK_EN to add a duplicated shadow bank whose
//            compressed result is compared against the primary path.
// Revision : 1.0 - initial release
// ============================================================================
module dom_indep_mul_ft #(
    parameter int D     = 1,
    parameter int CNT_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [D:0]           port_a,
    input  logic [D:0]           port_b,
    input  logic [D*(D+1)/2-1:0] port_r,
    output logic [D:0]           port_c,
    output logic                 out_valid,
    output logic                 port_f,
    output logic [CNT_W-1:0]     fault_cnt
);
    localparam int N = D + 1;

    // Partial products are stored row-major: element [i][j] lives at bit i*N+j.
    logic [N*N-1:0] w_q_d;
    logic [N*N-1:0] r_q;
    logic [N-1:0]   w_c;
    logic           r_out_valid;

    for (genvar i = 0; i < N; i++) begin : g_row
        for (genvar j = 0; j < N; j++) begin : g_col
            if (i == j) begin : g_inner
                assign w_q_d[i*N+j] = port_a[i] & port_b[j];
            end else if (i < j) begin : g_upper
                localparam int K = i*N - i*(i+1)/2 + (j-i-1);
                assign w_q_d[i*N+j] = (port_a[i] & port_b[j]) ^ port_r[K];
            end else begin : g_lower
                localparam int K = j*N - j*(j+1)/2 + (i-j-1);
                assign w_q_d[i*N+j] = (port_a[i] & port_b[j]) ^ port_r[K];
            end
        end
        assign w_c[i] = ^r_q[i*N +: N];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q         <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= in_valid;
            if (in_valid) begin
                r_q <= w_q_d;
            end
        end
    end

    assign out_valid = r_out_valid;

`ifdef DOM_FAULT_CHECK_EN
    // Shadow path uses its own gates and registers so a single upset cannot
    // corrupt both results identically.
    logic [N*N-1:0]   w_s_d;
    logic [N*N-1:0]   r_s;
    logic [N-1:0]     w_cs;
    logic             w_mismatch;
    logic             r_fault;
    logic [CNT_W-1:0] r_cnt;

    for (genvar i = 0; i < N; i++) begin : g_srow
        for (genvar j = 0; j < N; j++) begin : g_scol
            if (i == j) begin : g_inner
                assign w_s_d[i*N+j] = port_a[i] & port_b[j];
            end else if (i < j) begin : g_upper
                localparam int K = i*N - i*(i+1)/2 + (j-i-1);
                assign w_s_d[i*N+j] = (port_a[i] & port_b[j]) ^ port_r[K];
            end else begin : g_lower
                localparam int K = j*N - j*(j+1)/2 + (i-j-1);
                assign w_s_d[i*N+j] = (port_a[i] & port_b[j]) ^ port_r[K];
            end
        end
        assign w_cs[i] = ^r_s[i*N +: N];
    end

    assign w_mismatch = r_out_valid & (w_c != w_cs);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s     <= '0;
            r_fault <= 1'b0;
            r_cnt   <= '0;
        end else begin
            if (in_valid) begin
                r_s <= w_s_d;
            end
            if (w_mismatch) begin
                r_fault <= 1'b1;
                if (r_cnt != {CNT_W{1'b1}}) begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    assign port_c    = w_mismatch ? '0 : w_c;
    assign port_f    = r_fault;
    assign fault_cnt = r_cnt;
`else
    assign port_c    = w_c;
    assign port_f    = 1'b0;
    assign fault_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dom_indep_mul_ft.sv
`default_nettype none
// ============================================================================
// Module   : tb_dom_indep_mul_ft
// Purpose  : Directed self-checking bench for dom_indep_mul_ft (D=1 and D=2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_dom_indep_mul_ft;
    logic       clk;
    logic       rst;

    logic       iv1;
    logic [1:0] a1, b1;
    logic [0:0] r1;
    logic [1:0] c1;
    logic       ov1, f1;
    logic [1:0] cnt1;

    logic       iv2;
    logic [2:0] a2, b2, r2;
    logic [2:0] c2;
    logic       ov2, f2;
    logic [3:0] cnt2;

    int n_chk;
    int n_err;
    logic exp_bit;

    dom_indep_mul_ft #(.D(1), .CNT_W(2)) dut1 (
        .clk(clk), .rst(rst), .in_valid(iv1),
        .port_a(a1), .port_b(b1), .port_r(r1),
        .port_c(c1), .out_valid(ov1), .port_f(f1), .fault_cnt(cnt1)
    );

    dom_indep_mul_ft #(.D(2), .CNT_W(4)) dut2 (
        .clk(clk), .rst(rst), .in_valid(iv2),
        .port_a(a2), .port_b(b2), .port_r(r2),
        .port_c(c2), .out_valid(ov2), .port_f(f2), .fault_cnt(cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_chk = 0; n_err = 0;
        rst = 1'b1;
        iv1 = 1'b0; a1 = '0; b1 = '0; r1 = '0;
        iv2 = 1'b0; a2 = '0; b2 = '0; r2 = '0;
        tick(); tick();
        chk("rst_ov1",  32'(ov1),  0);
        chk("rst_c1",   32'(c1),   0);
        chk("rst_f1",   32'(f1),   0);
        chk("rst_cnt1", 32'(cnt1), 0);
        chk("rst_ov2",  32'(ov2),  0);
        chk("rst_c2",   32'(c2),   0);
        rst = 1'b0;

`ifdef DOM_FAULT_CHECK_EN
        // Disagreement while out_valid is low must be ignored.
        force dut1.r_s = 4'b0101;
        #1;
        chk("idle_mm_c", 32'(c1), 0);
        tick();
        release dut1.r_s;
        chk("idle_mm_f",   32'(f1),   0);
        chk("idle_mm_cnt", 32'(cnt1), 0);
`endif

        // a=01, b=01, r=1: q00=1 q01=1 q10=1 q11=0 -> c=2'b10
        a1 = 2'b01; b1 = 2'b01; r1 = 1'b1; iv1 = 1'b1;
        tick();
        chk("dir_ov", 32'(ov1), 1);
        chk("dir_c",  32'(c1),  32'h2);
        chk("dir_f",  32'(f1),  0);

        for (int v = 0; v < 32; v++) begin
            a1 = v[1:0]; b1 = v[3:2]; r1 = v[4];
            exp_bit = (^a1) & (^b1);
            tick();
            chk("exh_ov",  32'(ov1), 1);
            chk("exh_xor", 32'(^c1), 32'(exp_bit));
        end
        chk("exh_f",   32'(f1),   0);
        chk("exh_cnt", 32'(cnt1), 0);

        a1 = 2'b01; b1 = 2'b01; r1 = 1'b1;
        tick();
`ifdef DOM_FAULT_CHECK_EN
        // Real shadow content is 4'b0111; flip element [0][1].
        force dut1.r_s = 4'b0101;
        #1;
        chk("ft_c_zero", 32'(c1), 0);
        chk("ft_f_pre",  32'(f1), 0);
        tick();
        chk("ft_f",   32'(f1),   1);
        chk("ft_cnt", 32'(cnt1), 1);
        release dut1.r_s;
        // a=01, b=10, r=0: q01=1 only -> c=2'b01
        a1 = 2'b01; b1 = 2'b10; r1 = 1'b0;
        tick(); tick();
        chk("ft_recover_c", 32'(c1), 32'h1);
        chk("ft_sticky_f",  32'(f1), 1);
        for (int k = 0; k < 4; k++) begin
            force dut1.r_s = 4'b0000;
            #1;
            chk("ft_loop_c", 32'(c1), 0);
            tick();
        end
        release dut1.r_s;
        chk("ft_sat_cnt", 32'(cnt1), 3);
        chk("ft_sat_f",   32'(f1),   1);
`else
        chk("nf_c",   32'(c1),   32'h2);
        chk("nf_f",   32'(f1),   0);
        chk("nf_cnt", 32'(cnt1), 0);
`endif

        // Reset wins over a simultaneous valid input.
        rst = 1'b1; iv1 = 1'b1; a1 = 2'b11; b1 = 2'b11; r1 = 1'b0;
        tick();
        chk("rstv_ov",  32'(ov1),  0);
        chk("rstv_c",   32'(c1),   0);
        chk("rstv_f",   32'(f1),   0);
        chk("rstv_cnt", 32'(cnt1), 0);
        rst = 1'b0; iv1 = 1'b0;
        tick();

        // D=2 back-to-back stream.
        iv2 = 1'b1;
        for (int k = 0; k < 1000; k++) begin
            a2 = 3'($urandom_range(7));
            b2 = 3'($urandom_range(7));
            r2 = 3'($urandom_range(7));
            exp_bit = (^a2) & (^b2);
            tick();
            chk("d2_ov",  32'(ov2),  1);
            chk("d2_xor", 32'(^c2),  32'(exp_bit));
        end
        iv2 = 1'b0;
        tick();
        chk("d2_ov_drop", 32'(ov2),  0);
        chk("d2_f",       32'(f2),   0);
        chk("d2_cnt",     32'(cnt2), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/dom_indep_mul_ft.md
# dom_indep_mul_ft

Parametrised, pipelined, order-D domain-oriented-masking (DOM-indep) AND multiplier with a duplicated register bank and compression network for fault detection. Takes two N = D+1 share Boolean-masked bits plus fresh randomness and produces the masked product after one register stage. A mismatch between primary and shadow paths raises a sticky fault flag and zeroes the output. Sits in masked S-box datapaths as the nonlinear gadget, replacing the fixed first-order, single-output-check multiplier.

## Interface
Parameters:
- D, 1, security order; shares N = D+1; D ≥ 1
- CNT_W, 4, width of the saturating fault counter

Ports:
- clk  in  1  clock; all state on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  port_a/port_b/port_r valid this cycle
- port_a  in  N  shares of operand a (bit i = share i)
- port_b  in  N  shares of operand b
- port_r  in  D(D+1)/2  fresh randomness, one bit per unordered domain pair
- port_c  out  N  shares of c = a & b
- out_valid  out  1  port_c valid
- port_f  out  1  sticky fault flag
- fault_cnt  out  CNT_W  saturating count of fault cycles

## Operation
- Randomness index for pair i<j: k(i,j) = i·N − i(i+1)/2 + (j−i−1); pair (j,i) reuses k(i,j).
- Register stage, loaded when in_valid=1 (holds otherwise):
  - inner q[i][i] <= a_i & b_i
  - cross q[i][j] <= (a_i & b_j) ^ r[k(i,j)], i≠j
  - shadow bank s[i][j] loaded identically from independently instantiated AND/XOR gates (no shared combinational nodes)
- Compression (combinational from registers): c_i = XOR over j of q[i][j]; c'_i = XOR over j of s[i][j], separate gate trees.
- mismatch = out_valid & (c != c').
- port_c = mismatch ? 0 : c.
- Fault bookkeeping on clock edge: if mismatch, port_f <= 1; fault_cnt <= fault_cnt+1, saturating at 2^CNT_W−1. port_f clears only on rst.
- Unshared result: XOR of port_c = (XOR port_a) & (XOR port_b) for any port_r.

## Timing
- Latency 1: inputs with in_valid at edge t appear on port_c with out_valid=1 after edge t+1 (i.e. during cycle t+1).
- Throughput 1 per cycle; back-to-back in_valid accepted, no backpressure.
- out_valid <= in_valid each cycle.
- Reset values: out_valid=0, port_f=0, fault_cnt=0, q and s banks all 0, hence port_c=0.
- rst with in_valid=1 simultaneously: rst wins; out_valid=0 next cycle, no data captured.
- mismatch while out_valid=0: ignored (no flag, no count).
- fault_cnt at max with mismatch: stays at max; port_f stays 1.

## Configuration
- DOM_FAULT_CHECK_EN defined: shadow bank, shadow compression, mismatch gating, port_f and fault_cnt logic as above.
- Undefined: shadow bank and compare removed; port_c = c unconditionally; port_f and fault_cnt tied to 0. Ports remain for interface stability.

## Test plan
- D=1, a=2'b01, b=2'b01, r=1'b1, in_valid=1 -> next cycle out_valid=1, port_c=2'b10 (XOR=1), port_f=0.
- D=1, exhaustive 16 share pairs × r∈{0,1} -> XOR(port_c) = XOR(a)&XOR(b) every case, port_f=0, fault_cnt=0.
- D=2, 1000 back-to-back random vectors -> out_valid=1 every cycle after first, functional check holds, one-cycle latency.
- DOM_FAULT_CHECK_EN, force shadow s[0][1] flipped during a valid output -> port_c=0 that cycle, port_f=1 and fault_cnt=1 next cycle; flag remains 1 after force release; CNT_W=2 with 5 faults -> fault_cnt=3.
- Assert rst in same cycle as in_valid=1 after a fault -> out_valid=0, port_c=0, port_f=0, fault_cnt=0 next cycle.
- Macro undefined, same force as fault test -> port_f=0, fault_cnt=0, port_c unaffected.
